// File: rtl/cpu_exec_monitor.sv
// Execution monitor for the tinycpu core: retire counting, self-jump halt detection,
// fetch watchdog and a valid/ready trace FIFO of per-instruction register snapshots.
module cpu_exec_monitor #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HALT_REPEAT = 2,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [2:0]  FETCH_CODE  = 3'd0,
    parameter logic [2:0]  EXEC_CODE   = 3'd2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [2:0]               cpu_state,
    input  logic [1:0]               cpu_op,
    input  logic [DATA_W-1:0]        rA,
    input  logic [DATA_W-1:0]        rB,
    input  logic [DATA_W-1:0]        rM,
    input  logic [DATA_W-1:0]        rP,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [4*DATA_W-1:0]      trace_data,
    output logic [$clog2(DEPTH):0]   trace_level,
    output logic                     trace_overflow,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic                     halted,
    output logic [DATA_W-1:0]        halt_addr,
    output logic                     timeout
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LVL_W  = AW + 1;
    localparam int unsigned SNAP_W = 4 * DATA_W;
    localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);
    localparam int unsigned WD_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [2:0]        prev_state_q, prev_state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] halt_addr_q, halt_addr_d;
    logic              timeout_q, timeout_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [SNAP_W-1:0] mem_q [DEPTH];

    logic              gate, fetch_entry, exec_entry, push_req, pop, full, push_acc, hit;
    logic [DATA_W-1:0] p_dec;

    assign gate        = enable && !halted_q;
    assign fetch_entry = (cpu_state == FETCH_CODE) && (prev_state_q != FETCH_CODE);
    assign exec_entry  = (cpu_state == EXEC_CODE) && (prev_state_q != EXEC_CODE);
    assign push_req    = gate && fetch_entry;
    assign pop         = (level_q != '0) && trace_ready;
    assign full        = (level_q == LVL_W'(DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc    = push_req && (!full || pop) && !clear;
    assign p_dec       = rP - DATA_W'(1);
    assign hit         = gate && exec_entry && (cpu_op == 2'b11) && (p_dec == rM);

    always_comb begin
        prev_state_d = cpu_state;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        retire_d     = retire_q;
        halted_d     = halted_q;
        halt_addr_d  = halt_addr_q;
        timeout_d    = timeout_q;
        rep_d        = rep_q;
        cand_d       = cand_q;
        wd_d         = wd_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_acc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push_req && (retire_q != '1)) begin
            retire_d = retire_q + CNT_W'(1);
        end

        if (gate && exec_entry) begin
            if (hit) begin
                if (rM == cand_q) begin
                    rep_d = rep_q + REP_W'(1);
                end else begin
                    rep_d  = REP_W'(1);
                    cand_d = rM;
                end
                if (rep_d == REP_W'(HALT_REPEAT)) begin
                    halted_d    = 1'b1;
                    halt_addr_d = rM;
                end
            end else begin
                rep_d = '0;
            end
        end

        if ((TIMEOUT_CYC != 0) && gate) begin
            if (fetch_entry) begin
                wd_d = '0;
            end else if (wd_q != WD_W'(TIMEOUT_CYC)) begin
                wd_d = wd_q + WD_W'(1);
                if (wd_d == WD_W'(TIMEOUT_CYC)) begin
                    timeout_d = 1'b1;
                end
            end
        end

        // prev_state keeps tracking the core across a clear.
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            retire_d    = '0;
            halted_d    = 1'b0;
            halt_addr_d = '0;
            timeout_d   = 1'b0;
            rep_d       = '0;
            cand_d      = '0;
            wd_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_state_q <= FETCH_CODE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            retire_q     <= '0;
            halted_q     <= 1'b0;
            halt_addr_q  <= '0;
            timeout_q    <= 1'b0;
            rep_q        <= '0;
            cand_q       <= '0;
            wd_q         <= '0;
        end else begin
            prev_state_q <= prev_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
            halt_addr_q  <= halt_addr_d;
            timeout_q    <= timeout_d;
            rep_q        <= rep_d;
            cand_q       <= cand_d;
            wd_q         <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {rA, rB, rM, rP};
        end
    end

    assign trace_valid    = (level_q != '0);
    assign trace_data     = trace_valid ? mem_q[rd_ptr_q] : '0;
    assign trace_level    = level_q;
    assign trace_overflow = overflow_q;
    assign retire_cnt     = retire_q;
    assign halted         = halted_q;
    assign halt_addr      = halt_addr_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_cpu_exec_monitor.sv
// Directed bench: instance a (DEPTH=4, HALT_REPEAT=2, TIMEOUT_CYC=10) and
// instance b (HALT_REPEAT=1) sharing the core-side stimulus.
module tb_cpu_exec_monitor;

    logic        clk = 1'b0;
    logic        reset, enable, en_b, clear, ready;
    logic [2:0]  st;
    logic [1:0]  op;
    logic [7:0]  ra, rb, rm, rp;

    logic        a_valid, a_ovf, a_halted, a_tmo;
    logic [31:0] a_data;
    logic [2:0]  a_level;
    logic [15:0] a_retire;
    logic [7:0]  a_haddr;

    logic        b_valid, b_ovf, b_halted, b_tmo;
    logic [31:0] b_data;
    logic [2:0]  b_level;
    logic [15:0] b_retire;
    logic [7:0]  b_haddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_exec_monitor #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .HALT_REPEAT(2), .TIMEOUT_CYC(10),
                       .FETCH_CODE(3'd0), .EXEC_CODE(3'd2)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .cpu_state(st), .cpu_op(op), .rA(ra), .rB(rb), .rM(rm), .rP(rp),
        .trace_valid(a_valid), .trace_ready(ready), .trace_data(a_data),
        .trace_level(a_level), .trace_overflow(a_ovf), .retire_cnt(a_retire),
        .halted(a_halted), .halt_addr(a_haddr), .timeout(a_tmo));

    cpu_exec_monitor #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .HALT_REPEAT(1), .TIMEOUT_CYC(10),
                       .FETCH_CODE(3'd0), .EXEC_CODE(3'd2)) u_b (
        .clk(clk), .reset(reset), .enable(en_b), .clear(clear),
        .cpu_state(st), .cpu_op(op), .rA(ra), .rB(rb), .rM(rm), .rP(rp),
        .trace_valid(b_valid), .trace_ready(ready), .trace_data(b_data),
        .trace_level(b_level), .trace_overflow(b_ovf), .retire_cnt(b_retire),
        .halted(b_halted), .halt_addr(b_haddr), .timeout(b_tmo));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_cycle(input logic [31:0] snap);
        st = 3'd1; tick();
        st = 3'd2; tick();
        st = 3'd0;
        {ra, rb, rm, rp} = snap;
        tick();
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0;
        enable = 1'($urandom); en_b = 1'($urandom); ready = 1'($urandom);
        st = 3'($urandom); op = 2'($urandom);
        ra = 8'($urandom); rb = 8'($urandom); rm = 8'($urandom); rp = 8'($urandom);
        tick(); tick();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_flags", {28'd0, a_ovf, a_halted, a_tmo, b_halted}, 32'd0);
        chk("rst_retire", 32'(a_retire), 32'd0);
        chk("rst_haddr", 32'(a_haddr), 32'd0);

        st = 3'd0; op = 2'd0; enable = 1'b1; en_b = 1'b0; ready = 1'b1;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("idle_level", 32'(a_level), 32'd0);
        chk("idle_retire", 32'(a_retire), 32'd0);

        // Trace and retire
        st = 3'd1; tick();
        st = 3'd2; tick();
        chk("tr_pre_valid", 32'(a_valid), 32'd0);
        st = 3'd0; {ra, rb, rm, rp} = 32'h11223344; tick();
        chk("tr1_valid", 32'(a_valid), 32'd1);
        chk("tr1_data", a_data, 32'h11223344);
        st = 3'd1; {ra, rb, rm, rp} = 32'h99999999; tick();
        chk("tr1_drained", 32'(a_valid), 32'd0);
        st = 3'd2; tick();
        st = 3'd0; {ra, rb, rm, rp} = 32'h55667788; tick();
        chk("tr2_data", a_data, 32'h55667788);
        st = 3'd1; tick();
        chk("tr_retire", 32'(a_retire), 32'd2);

        // Halt after two identical self-jumps
        st = 3'd2; op = 2'b11; rp = 8'h11; rm = 8'h10; tick();
        chk("h_first", 32'(a_halted), 32'd0);
        st = 3'd0; tick();
        st = 3'd1; tick();
        st = 3'd2; tick();
        chk("h_halted", 32'(a_halted), 32'd1);
        chk("h_addr", 32'(a_haddr), 32'h10);
        st = 3'd0; tick();
        chk("h_no_retire", 32'(a_retire), 32'd3);
        chk("h_no_push", 32'(a_level), 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_halted", 32'(a_halted), 32'd0);
        chk("clr_retire", 32'(a_retire), 32'd0);

        // Differing targets must not halt
        st = 3'd1; tick();
        st = 3'd2; rp = 8'h11; rm = 8'h10; tick();
        st = 3'd0; tick();
        st = 3'd1; tick();
        st = 3'd2; rp = 8'h21; rm = 8'h20; tick();
        chk("nh_halted", 32'(a_halted), 32'd0);
        st = 3'd0; tick();
        chk("nh_retire", 32'(a_retire), 32'd2);

        // Wrap-around address on the HALT_REPEAT=1 instance, a frozen
        enable = 1'b0; en_b = 1'b1;
        st = 3'd1; tick();
        st = 3'd2; rp = 8'h00; rm = 8'hFF; tick();
        chk("wr_halted", 32'(b_halted), 32'd1);
        chk("wr_addr", 32'(b_haddr), 32'hFF);
        chk("wr_a_frozen", 32'(a_retire), 32'd2);
        enable = 1'b1; en_b = 1'b0; op = 2'd0;
        clear = 1'b1; tick(); clear = 1'b0;

        // FIFO full and overflow
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fetch_cycle(32'hA0B0C0D0 + 32'h01010101 * 32'(i));
        end
        chk("ff_level", 32'(a_level), 32'd4);
        chk("ff_ovf", 32'(a_ovf), 32'd1);
        chk("ff_head", a_data, 32'hA0B0C0D0);
        chk("ff_retire", 32'(a_retire), 32'd6);
        st = 3'd1; tick();
        st = 3'd2; tick();
        st = 3'd0; {ra, rb, rm, rp} = 32'hA6B6C6D6; ready = 1'b1; tick();
        chk("fp_level", 32'(a_level), 32'd4);
        chk("fp_head1", a_data, 32'hA1B1C1D1);
        st = 3'd1; tick();
        chk("fp_head2", a_data, 32'hA2B2C2D2);
        tick();
        chk("fp_head3", a_data, 32'hA3B3C3D3);
        tick();
        chk("fp_head6", a_data, 32'hA6B6C6D6);
        chk("fp_level1", 32'(a_level), 32'd1);
        tick();
        chk("fp_empty", 32'(a_valid), 32'd0);

        // Watchdog and clear
        clear = 1'b1; tick(); clear = 1'b0;
        chk("wd_clr_ovf", 32'(a_ovf), 32'd0);
        st = 3'd0; tick();
        st = 3'd1;
        repeat (9) tick();
        chk("wd_cyc9", 32'(a_tmo), 32'd0);
        tick();
        chk("wd_cyc10", 32'(a_tmo), 32'd1);
        tick(); tick();
        chk("wd_sticky", 32'(a_tmo), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("fin_flags", {28'd0, a_ovf, a_halted, a_tmo, a_valid}, 32'd0);
        chk("fin_retire", 32'(a_retire), 32'd0);
        chk("fin_level", 32'(a_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_exec_monitor.md
Name: cpu_exec_monitor

Overview:
- Parametrised, synthesizable execution monitor that sits beside the tinycpu core and observes its control state, current opcode and architectural registers A, B, M, P.
- Detects the self-jump halt idiom with a configurable repeat count and counts retired instructions.
- Flags stalled execution through a cycle watchdog.
- Buffers per-instruction register snapshots in a FIFO with a valid/ready drain port, so benches and on-chip debug logic consume trace data at their own rate.

Parameters:
- DATA_W, 8: width of each CPU register.
- DEPTH, 8: trace FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the retire counter.
- HALT_REPEAT, 2: consecutive qualifying self-jumps required to declare halt; at least 1.
- TIMEOUT_CYC, 64: maximum cycles between fetch entries; 0 disables the watchdog.
- FETCH_CODE, 3'd0: state encoding of the fetch state.
- EXEC_CODE, 3'd2: state encoding of the execute state.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: monitoring enable.
- clear, input, 1: synchronous clear of counters, flags and FIFO.
- cpu_state, input, 3: CPU control state.
- cpu_op, input, 2: instruction bits [7:6].
- rA, rB, rM, rP, input, DATA_W each: CPU registers.
- trace_valid, output, 1: FIFO head valid.
- trace_ready, input, 1: consumer accepts the head.
- trace_data, output, 4*DATA_W: head snapshot {A,B,M,P}, A in the MSBs.
- trace_level, output, clog2(DEPTH)+1: FIFO occupancy.
- trace_overflow, output, 1: sticky; a snapshot was dropped.
- retire_cnt, output, CNT_W: saturating count of fetch entries.
- halted, output, 1: sticky halt detected.
- halt_addr, output, DATA_W: rM captured at the halt declaration.
- timeout, output, 1: sticky watchdog expiry.

Behaviour:
- Reset (reset low, asynchronous): every output is 0, the FIFO is empty, and the previous-state register holds FETCH_CODE.
- Event definitions:
  - fetch_entry = cpu_state==FETCH_CODE and prev_state!=FETCH_CODE. After reset the first fetch_entry is therefore suppressed until the state leaves fetch and returns.
  - exec_entry = cpu_state==EXEC_CODE and prev_state!=EXEC_CODE.
  - prev_state updates every cycle regardless of enable or halted.
- Gating: all counting, pushes and detection require enable=1 and halted=0. With enable=0, counters, flags and the FIFO contents freeze; popping continues.
- Snapshot push:
  - On a gated fetch_entry, {rA,rB,rM,rP} from that cycle is pushed.
  - The entry is visible on trace_data one cycle later: trace_valid rises on the next edge when the FIFO was empty.
- FIFO pop: a pop occurs when trace_valid and trace_ready are both high.
- FIFO full:
  - A push while full and not popping in the same cycle is dropped, and trace_overflow is set.
  - A push while full with a simultaneous pop is accepted; the level is unchanged.
- FIFO empty: trace_ready is ignored. A push into an empty FIFO cannot be popped in the same cycle.
- Pointers: wrap modulo DEPTH. trace_level equals the number of valid entries, 0 to DEPTH.
- retire_cnt: increments on each gated fetch_entry and saturates at all-ones.
- Halt detection:
  - hit = gated exec_entry and cpu_op==2'b11 and (rP - 1) mod 2^DATA_W == rM. For example, rP=0 and rM=all-ones is a hit.
  - rep_cnt:
    - on a hit with rM equal to the stored candidate address, rep_cnt increments;
    - on a hit with a different rM, rep_cnt becomes 1 and the candidate becomes rM;
    - on a gated exec_entry that is not a hit, rep_cnt clears to 0.
  - When rep_cnt reaches HALT_REPEAT, halted is set on that edge and halt_addr captures rM. With HALT_REPEAT=1, the first hit halts.
  - After halt, pushes, retire counting and the watchdog stop; the FIFO can still be drained.
- Watchdog:
  - A cycle counter clears on every gated fetch_entry and increments every other gated cycle.
  - When the counter equals TIMEOUT_CYC, timeout is set and the counter holds.
  - TIMEOUT_CYC=0 disables the watchdog.
- clear:
  - Synchronous; restores the reset values of the counters, flags, FIFO and rep_cnt. prev_state is left unchanged.
  - It wins over any push, pop or detection in the same cycle.
- Asynchronous reset mid-operation: everything returns to reset values immediately, including the FIFO.

Test Plan:
- Reset and idle: hold reset low for 2 cycles with random inputs. Required: all outputs 0 and trace_level=0. Release reset with cpu_state=0 held. Required: no push and retire_cnt stays 0.
- Trace and retire:
  - Drive the state sequence 0,1,2,0,1,2,0 with the registers changing at each fetch and trace_ready=1.
  - Required: 2 snapshots, each appearing exactly 1 cycle after its fetch_entry, with the exact {A,B,M,P} values; retire_cnt=2.
- Halt with HALT_REPEAT=2:
  - Execute a jump with rP=0x11, rM=0x10, twice in consecutive instructions. Required: halted=1 after the second exec_entry and halt_addr=0x10.
  - Repeat with the targets 0x10 then 0x20. Required: no halt.
- Wrap-around: with DATA_W=8 and HALT_REPEAT=1, execute a jump with rP=0x00, rM=0xFF. Required: halted=1 and halt_addr=0xFF.
- FIFO full with DEPTH=4:
  - Hold trace_ready=0 and generate 6 fetch entries. Required: trace_level=4, trace_overflow=1, and the head equals the first snapshot.
  - Raise trace_ready while a push arrives. Required: level stays 4 and the order is preserved.
- Watchdog and clear:
  - With TIMEOUT_CYC=10, hold cpu_state=1 for 12 cycles. Required: timeout=1 on cycle 10.
  - Pulse clear. Required: all flags and counters are 0 on the next edge.
